// File: rtl/rotary_accumulator.sv
// Rotary encoder accumulator with bounded value, saturate/wrap selection and
// speed-dependent acceleration (IDLE -> RUN -> FAST) driven by step intervals.
module rotary_accumulator #(
    parameter int WIDTH       = 8,
    parameter int MIN_VALUE   = 0,
    parameter int MAX_VALUE   = 255,
    parameter int WRAP        = 0,
    parameter int RESET_VALUE = 0,
    parameter int FAST_WINDOW = 50000,
    parameter int FAST_COUNT  = 3,
    parameter int FAST_STEP   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_ccw,
    input  logic             in_cw,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             at_min,
    output logic             at_max,
    output logic             accel
);

    // Two guard bits keep value +/- step and the clamp comparisons free of overflow.
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(FAST_WINDOW + 1);
    localparam int RW = $clog2(FAST_COUNT + 1);

    localparam logic [CW-1:0]        WINDOW_C   = CW'(FAST_WINDOW);
    localparam logic [RW-1:0]        RUN_MAX    = RW'(FAST_COUNT);
    localparam logic [RW-1:0]        RUN_LAST   = RW'(FAST_COUNT - 1);
    localparam logic [WIDTH-1:0]     MIN_W      = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0]     MAX_W      = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0]     RESET_W    = WIDTH'(RESET_VALUE);
    localparam logic signed [AW-1:0] MIN_S      = AW'(MIN_VALUE);
    localparam logic signed [AW-1:0] MAX_S      = AW'(MAX_VALUE);
    localparam logic signed [AW-1:0] RANGE_S    = AW'(MAX_VALUE - MIN_VALUE + 1);
    localparam logic signed [AW-1:0] FAST_S     = AW'(FAST_STEP);
    localparam logic signed [AW-1:0] ONE_S      = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [RW-1:0]    run_cnt_q, run_cnt_d;
    logic [CW-1:0]    interval_q, interval_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             changed_q;
    logic             big_step;

    logic step_cw, step_ccw, step, conflict, fast_step;
    logic signed [AW-1:0] cur, mag, sum, res, lv, lv_c;

    // A step needs exactly one direction pulse and no load; both pulses together freeze everything.
    assign step_cw   = in_cw & ~in_ccw & ~load;
    assign step_ccw  = in_ccw & ~in_cw & ~load;
    assign step      = step_cw | step_ccw;
    assign conflict  = in_cw & in_ccw & ~load;
    assign fast_step = (interval_q < WINDOW_C);

    // State register: FSM, run tracking, interval timer, value and change flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            run_cnt_q  <= '0;
            interval_q <= WINDOW_C;
            value_q    <= RESET_W;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            run_cnt_q  <= run_cnt_d;
            interval_q <= interval_d;
            value_q    <= value_d;
            changed_q  <= (value_d != value_q);
        end
    end

    // Next-state logic: run building, acceleration entry/exit and idle timeout.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        run_cnt_d = run_cnt_q;
        big_step  = 1'b0;
        if (load) begin
            state_d   = IDLE;
            run_cnt_d = '0;
        end else if (step) begin
            if (state_q != IDLE && fast_step && (step_cw == dir_q)) begin
                if (state_q == FAST) begin
                    big_step = 1'b1;
                end else begin
                    if (run_cnt_q < RUN_MAX) begin
                        run_cnt_d = run_cnt_q + RW'(1);
                    end
                    if (run_cnt_q >= RUN_LAST) begin
                        state_d = FAST;
                    end
                end
            end else begin
                state_d   = RUN;
                dir_d     = step_cw;
                run_cnt_d = RW'(1);
            end
        end else if (!conflict && interval_q == WINDOW_C) begin
            state_d   = IDLE;
            run_cnt_d = '0;
        end
    end

    // Interval timer: clears on a step, holds on a conflict, otherwise counts up to the window.
    always_comb begin
        interval_d = interval_q;
        if (step) begin
            interval_d = '0;
        end else if (!conflict && interval_q < WINDOW_C) begin
            interval_d = interval_q + CW'(1);
        end
    end

    // Datapath: signed add/subtract, then wrap or clamp; loads are clamped into range.
    // Wrapping uses a single range correction, so FAST_STEP must not exceed the range.
    always_comb begin
        cur  = $signed({2'b00, value_q});
        mag  = big_step ? FAST_S : ONE_S;
        sum  = step_cw ? (cur + mag) : (cur - mag);
        res  = sum;
        if (WRAP != 0) begin
            if (sum > MAX_S) begin
                res = sum - RANGE_S;
            end else if (sum < MIN_S) begin
                res = sum + RANGE_S;
            end
        end else begin
            if (sum > MAX_S) begin
                res = MAX_S;
            end else if (sum < MIN_S) begin
                res = MIN_S;
            end
        end
        lv   = $signed({2'b00, load_value});
        lv_c = lv;
        if (lv > MAX_S) begin
            lv_c = MAX_S;
        end else if (lv < MIN_S) begin
            lv_c = MIN_S;
        end
        value_d = value_q;
        if (load) begin
            value_d = WIDTH'(lv_c);
        end else if (step) begin
            value_d = WIDTH'(res);
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        at_min = (value_q == MIN_W);
        at_max = (value_q == MAX_W);
        accel  = (state_q == FAST);
    end

    assign value   = value_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_rotary_accumulator.sv
// Scoreboard bench for rotary_accumulator: a saturating and a wrapping instance
// share stimulus; a step-level reference model predicts each result.
module tb_rotary_accumulator;

    localparam int WINDOW = 50000;

    logic       clk = 1'b0;
    logic       rst_n, in_cw, in_ccw, load;
    logic [7:0] load_value;
    logic [7:0] value0, value1;
    logic       changed0, changed1, at_min0, at_min1, at_max0, at_max1, accel0, accel1;

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    rotary_accumulator #(.WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_ccw(in_ccw), .in_cw(in_cw), .load(load),
        .load_value(load_value), .value(value0), .changed(changed0),
        .at_min(at_min0), .at_max(at_max0), .accel(accel0)
    );

    rotary_accumulator #(.WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_ccw(in_ccw), .in_cw(in_cw), .load(load),
        .load_value(load_value), .value(value1), .changed(changed1),
        .at_min(at_min1), .at_max(at_max1), .accel(accel1)
    );

    typedef struct {
        string tag;
        int    v0;
        int    v1;
        bit    ch0;
        bit    ch1;
        bit    acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model: value for each variant, FSM state (0 idle, 1 run, 2 fast), run length.
    int m_v0, m_v1, m_state, m_run, m_last;
    bit m_dir;

    task automatic checkOutput(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic int satv(input int s);
        if (s > 255) return 255;
        if (s < 0) return 0;
        return s;
    endfunction

    function automatic int wrapv(input int s);
        if (s > 255) return s - 256;
        if (s < 0) return s + 256;
        return s;
    endfunction

    task automatic modelStep(input bit cw);
        int  n;
        int  d;
        bit  fast;
        n      = edge_cnt + 1 - m_last;
        fast   = (n <= WINDOW);
        m_last = edge_cnt + 1;
        d      = 1;
        if (m_state == 0 || !fast || cw != m_dir) begin
            m_state = 1;
            m_dir   = cw;
            m_run   = 1;
        end else if (m_state == 1) begin
            m_run++;
            if (m_run >= 3) m_state = 2;
        end else begin
            d = 10;
        end
        if (!cw) d = -d;
        m_v0 = satv(m_v0 + d);
        m_v1 = wrapv(m_v1 + d);
    endtask

    task automatic compareFront();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        checkOutput({e.tag, ".value_sat"},   int'(value0),   e.v0);
        checkOutput({e.tag, ".value_wrap"},  int'(value1),   e.v1);
        checkOutput({e.tag, ".changed_sat"}, int'(changed0), int'(e.ch0));
        checkOutput({e.tag, ".changed_wrap"},int'(changed1), int'(e.ch1));
        checkOutput({e.tag, ".accel_sat"},   int'(accel0),   int'(e.acc));
        checkOutput({e.tag, ".accel_wrap"},  int'(accel1),   int'(e.acc));
        checkOutput({e.tag, ".at_max_sat"},  int'(at_max0),  int'(e.v0 == 255));
        checkOutput({e.tag, ".at_min_wrap"}, int'(at_min1),  int'(e.v1 == 0));
    endtask

    task automatic applyStimulus(input string tag, input bit cw, input bit ccw,
                                 input bit ld, input int lv);
        exp_t e;
        int   old0, old1;
        old0       = m_v0;
        old1       = m_v1;
        in_cw      = cw;
        in_ccw     = ccw;
        load       = ld;
        load_value = 8'(lv);
        if (ld) begin
            m_v0    = satv(lv);
            m_v1    = satv(lv);
            m_state = 0;
        end else if (cw ^ ccw) begin
            modelStep(cw);
        end
        e.tag = tag;
        e.v0  = m_v0;
        e.v1  = m_v1;
        e.ch0 = (m_v0 != old0);
        e.ch1 = (m_v1 != old1);
        e.acc = (m_state == 2);
        sb.push_back(e);
        tick();
        in_cw  = 1'b0;
        in_ccw = 1'b0;
        load   = 1'b0;
        compareFront();
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        tick();
        checkOutput({tag, ".value_sat"},   int'(value0),   0);
        checkOutput({tag, ".value_wrap"},  int'(value1),   0);
        checkOutput({tag, ".changed_sat"}, int'(changed0), 0);
        checkOutput({tag, ".accel_sat"},   int'(accel0),   0);
        checkOutput({tag, ".accel_wrap"},  int'(accel1),   0);
        checkOutput({tag, ".at_min_sat"},  int'(at_min0),  1);
        checkOutput({tag, ".at_max_sat"},  int'(at_max0),  0);
        rst_n   = 1'b1;
        m_v0    = 0;
        m_v1    = 0;
        m_state = 0;
        m_run   = 0;
        m_dir   = 1'b0;
        m_last  = -1000000;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_cw      = 1'b0;
        in_ccw     = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        tick();
        doReset("reset");

        // Three cw pulses 1000 cycles apart.
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("slow_cw%0d", i), 1'b1, 1'b0, 1'b0, 0);
            idle(1000);
        end
        checkOutput("changed_drop", int'(changed0), 0);

        // Six cw pulses 100 apart from zero: acceleration after the third.
        doReset("reset2");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("fast_cw%0d", i), 1'b1, 1'b0, 1'b0, 0);
            idle(100);
        end

        // Reversal leaves FAST, then a long gap times out to IDLE.
        applyStimulus("reverse_ccw", 1'b0, 1'b1, 1'b0, 0);
        idle(60000);
        checkOutput("timeout_accel_sat", int'(accel0), 0);
        checkOutput("timeout_accel_wrap", int'(accel1), 0);
        applyStimulus("after_timeout_cw", 1'b1, 1'b0, 1'b0, 0);

        // Load near the top and spin quickly: clamp vs wrap.
        applyStimulus("load254", 1'b0, 1'b0, 1'b1, 254);
        for (int i = 0; i < 5; i++) begin
            idle(2);
            applyStimulus($sformatf("top_cw%0d", i), 1'b1, 1'b0, 1'b0, 0);
        end

        // Conflicting pulses are ignored; load beats a step.
        idle(3);
        applyStimulus("both_pulses", 1'b1, 1'b1, 1'b0, 0);
        applyStimulus("load_vs_cw", 1'b1, 1'b0, 1'b1, 7);

        // Reach FAST at 120, reset, then confirm a plain single step.
        applyStimulus("load97", 1'b0, 1'b0, 1'b1, 97);
        for (int i = 0; i < 5; i++) begin
            idle(5);
            applyStimulus($sformatf("climb_cw%0d", i), 1'b1, 1'b0, 1'b0, 0);
        end
        doReset("reset_in_fast");
        idle(2);
        applyStimulus("post_reset_cw", 1'b1, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
